// File: rtl/fc_sched_pkg.sv
// Shared types, layer table and address helper for the 3-layer FC scheduler.
// Latency: n/a (package). Backpressure: n/a.
package fc_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WAIT,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam int NUM_LAYERS = 3;
    localparam int GAP_CYCLES = 2;

    localparam logic [1:0] LAST_LAYER = 2'(NUM_LAYERS - 1);
    localparam logic [1:0] GAP_LAST   = 2'(GAP_CYCLES - 1);

    // Index 0 is layer0 (packed arrays list the highest index first).
    localparam logic [NUM_LAYERS-1:0][1:0] NTH        = {2'd2, 2'd1, 2'd0};
    localparam logic [NUM_LAYERS-1:0][8:0] IN_NUM     = {9'd84, 9'd120, 9'd400};
    localparam logic [NUM_LAYERS-1:0][6:0] OUT_NUM    = {7'd10, 7'd84, 7'd120};
    localparam logic [NUM_LAYERS-1:0][9:0] IFMAP_BASE = {10'd520, 10'd400, 10'd0};

    // Highest ifmap address of the region the given layer writes into,
    // i.e. next-layer base + out - 1; outputs land there in reverse order.
    function automatic logic [9:0] wb_top_addr(input logic [1:0] layer);
        logic [1:0] nxt;
        nxt = (layer == 2'd0) ? 2'd1 : 2'd2;
        return IFMAP_BASE[nxt] + {3'b000, OUT_NUM[layer]} - 10'd1;
    endfunction

endpackage

// File: rtl/fc_layer_sched_if.sv
// Command / result-stream / writeback bundle between the FC scheduler and its peers.
// Latency: n/a (wiring). Backpressure: none, streams are valid-only.
interface fc_layer_sched_if;

    logic              start_i;
    logic              abort_i;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic              fc_start_o;
    logic [1:0]        fc_nth_fully_o;
    logic [8:0]        fc_in_node_num_o;
    logic [6:0]        fc_out_node_num_o;
    logic signed [7:0] fc_result_i;
    logic              fc_valid_i;
    logic              fc_last_i;
    logic              ifmap_wren_o;
    logic [9:0]        ifmap_wrptr_o;
    logic [7:0]        ifmap_wdata_o;
    logic              result_valid_o;
    logic [7:0]        result_o;
    logic              result_last_o;

    modport master (
        output start_i, abort_i, fc_result_i, fc_valid_i, fc_last_i,
        input  busy_o, done_o, err_o, fc_start_o, fc_nth_fully_o,
               fc_in_node_num_o, fc_out_node_num_o, ifmap_wren_o,
               ifmap_wrptr_o, ifmap_wdata_o, result_valid_o, result_o,
               result_last_o
    );

    modport slave (
        input  start_i, abort_i, fc_result_i, fc_valid_i, fc_last_i,
        output busy_o, done_o, err_o, fc_start_o, fc_nth_fully_o,
               fc_in_node_num_o, fc_out_node_num_o, ifmap_wren_o,
               ifmap_wrptr_o, ifmap_wdata_o, result_valid_o, result_o,
               result_last_o
    );

endinterface

// File: rtl/fc_sched_wb.sv
// Writeback/result register: reversed ifmap address for layer0/1, result stream for layer2.
// Latency: 1 cycle from en. Backpressure: none; FC_SCHED_RELU_EN clips writeback data at 0.
module fc_sched_wb
    import fc_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [1:0]        layer,
    input  logic [6:0]        idx,
    input  logic signed [7:0] data,
    output logic              wren,
    output logic [9:0]        wrptr,
    output logic [7:0]        wdata,
    output logic              res_vld,
    output logic [7:0]        res,
    output logic              res_last
);

    logic       is_final;
    logic       wr_en;
    logic       rs_en;
    logic [7:0] wb_data;

    assign is_final = (layer == LAST_LAYER);
    assign wr_en    = en & ~is_final;
    assign rs_en    = en & is_final;

`ifdef FC_SCHED_RELU_EN
    assign wb_data = data[7] ? 8'd0 : data;
`else
    assign wb_data = data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wren     <= 1'b0;
            wrptr    <= '0;
            wdata    <= '0;
            res_vld  <= 1'b0;
            res      <= '0;
            res_last <= 1'b0;
        end else if (clr) begin
            wren     <= 1'b0;
            wrptr    <= '0;
            wdata    <= '0;
            res_vld  <= 1'b0;
            res      <= '0;
            res_last <= 1'b0;
        end else begin
            wren     <= wr_en;
            wrptr    <= wr_en ? (wb_top_addr(layer) - {3'b000, idx}) : '0;
            wdata    <= wr_en ? wb_data : '0;
            res_vld  <= rs_en;
            res      <= rs_en ? data : '0;
            res_last <= rs_en & (idx == OUT_NUM[LAST_LAYER] - 7'd1);
        end
    end

endmodule

// File: rtl/fc_layer_sched.sv
// Sequences the fixed 3-layer FC chain: command, collect outputs, write back, gap. Optional FC_SCHED_RELU_EN.
// Latency: writeback/result 1 cycle after fc_valid_i. Backpressure: none; surplus samples are dropped and flagged.
module fc_layer_sched
    import fc_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    fc_layer_sched_if.slave   bus
);

    state_t     state, state_nxt;
    logic [1:0] layer, layer_nxt;
    logic [6:0] idx, idx_nxt;
    logic [1:0] gap_cnt, gap_nxt;
    logic       err, err_nxt;
    logic       wb_en;
    logic       start_acc;
    logic       cmd_act;
    logic [6:0] last_idx;

    assign start_acc = (state == ST_IDLE) & bus.start_i & ~bus.abort_i;
    assign last_idx  = OUT_NUM[layer] - 7'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            layer   <= 2'd0;
            idx     <= 7'd0;
            gap_cnt <= 2'd0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            layer   <= layer_nxt;
            idx     <= idx_nxt;
            gap_cnt <= gap_nxt;
            err     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        layer_nxt = layer;
        idx_nxt   = idx;
        gap_nxt   = gap_cnt;
        err_nxt   = err;
        wb_en     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start_acc) begin
                    state_nxt = ST_CMD;
                    layer_nxt = 2'd0;
                    idx_nxt   = 7'd0;
                    err_nxt   = 1'b0;
                end
            end
            ST_CMD: begin
                state_nxt = ST_WAIT;
                idx_nxt   = 7'd0;
            end
            ST_WAIT: begin
                if (bus.fc_valid_i) begin
                    if (bus.fc_last_i) begin
                        if (idx != last_idx) err_nxt = 1'b1;
                        wb_en     = 1'b1;
                        state_nxt = ST_GAP;
                        gap_nxt   = 2'd0;
                        idx_nxt   = 7'd0;
                    end else if (idx == last_idx) begin
                        // Stream overran the layer size: flag and drop.
                        err_nxt = 1'b1;
                    end else begin
                        wb_en   = 1'b1;
                        idx_nxt = idx + 7'd1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_nxt = 2'd0;
                    if (layer == LAST_LAYER) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_CMD;
                        layer_nxt = layer + 2'd1;
                    end
                end else begin
                    gap_nxt = gap_cnt + 2'd1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                layer_nxt = 2'd0;
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (bus.fc_valid_i && state != ST_WAIT) err_nxt = 1'b1;

        if (bus.abort_i) begin
            state_nxt = ST_IDLE;
            layer_nxt = 2'd0;
            idx_nxt   = 7'd0;
            gap_nxt   = 2'd0;
            wb_en     = 1'b0;
        end
    end

    assign cmd_act               = (state == ST_CMD) | (state == ST_WAIT) | (state == ST_GAP);
    assign bus.busy_o            = (state != ST_IDLE);
    assign bus.done_o            = (state == ST_DONE);
    assign bus.err_o             = err;
    assign bus.fc_start_o        = (state == ST_CMD);
    assign bus.fc_nth_fully_o    = cmd_act ? NTH[layer]     : 2'd0;
    assign bus.fc_in_node_num_o  = cmd_act ? IN_NUM[layer]  : 9'd0;
    assign bus.fc_out_node_num_o = cmd_act ? OUT_NUM[layer] : 7'd0;

    fc_sched_wb u_wb (
        .clk      (clk),
        .rst      (rst),
        .clr      (bus.abort_i),
        .en       (wb_en),
        .layer    (layer),
        .idx      (idx),
        .data     (bus.fc_result_i),
        .wren     (bus.ifmap_wren_o),
        .wrptr    (bus.ifmap_wrptr_o),
        .wdata    (bus.ifmap_wdata_o),
        .res_vld  (bus.result_valid_o),
        .res      (bus.result_o),
        .res_last (bus.result_last_o)
    );

endmodule

// File: tb/tb_fc_layer_sched.sv
// Randomized scoreboard bench for fc_layer_sched; honours FC_SCHED_RELU_EN when defined.
module tb_fc_layer_sched;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fc_layer_sched_if bus();

    fc_layer_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct { int addr; int data; } wr_t;
    typedef struct { int data; int last; } rs_t;
    typedef struct { int nth; int in_n; int out_n; } cmd_t;

    int IN_N [3] = '{400, 120, 84};
    int OUT_N[3] = '{120, 84, 10};
    int BASE [3] = '{0, 400, 520};

    wr_t  wq[$];
    rs_t  rq[$];
    cmd_t cq[$];

    int checks = 0;
    int errors = 0;
    int exp_done = 0;
    int done_seen = 0;
    int exp_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int relu(input logic [7:0] d);
`ifdef FC_SCHED_RELU_EN
        return d[7] ? 0 : int'(d);
`else
        return int'(d);
`endif
    endfunction

    // Expected effect of an accepted sample that is the pos-th output of layer L.
    task automatic push_out(input int L, input int pos, input logic [7:0] d);
        if (L < 2) wq.push_back('{BASE[L+1] + OUT_N[L] - 1 - pos, relu(d)});
        else       rq.push_back('{int'(d), (pos == OUT_N[2] - 1) ? 1 : 0});
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (bus.ifmap_wren_o) begin
                if (wq.size() == 0) chk("spurious_write", int'(bus.ifmap_wren_o), 0);
                else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("wrptr", int'(bus.ifmap_wrptr_o), w.addr);
                    chk("wdata", int'(bus.ifmap_wdata_o), w.data);
                end
            end
            if (bus.result_valid_o) begin
                if (rq.size() == 0) chk("spurious_result", int'(bus.result_valid_o), 0);
                else begin
                    rs_t r;
                    r = rq.pop_front();
                    chk("result", int'(bus.result_o), r.data);
                    chk("result_last", int'(bus.result_last_o), r.last);
                end
            end
            if (bus.fc_start_o) begin
                if (cq.size() == 0) chk("spurious_fc_start", int'(bus.fc_start_o), 0);
                else begin
                    cmd_t c;
                    c = cq.pop_front();
                    chk("cmd_nth", int'(bus.fc_nth_fully_o), c.nth);
                    chk("cmd_in", int'(bus.fc_in_node_num_o), c.in_n);
                    chk("cmd_out", int'(bus.fc_out_node_num_o), c.out_n);
                end
            end
            if (bus.done_o) done_seen++;
        end
    end

    task automatic push_cmd(input int L);
        cq.push_back('{L, IN_N[L], OUT_N[L]});
    endtask

    task automatic wait_cmd();
        bit ok;
        ok = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            if (bus.fc_start_o) begin
                ok = 1;
                break;
            end
        end
        chk("cmd_timeout", int'(ok), 1);
    endtask

    task automatic send_layer(input int L, input int nv, input int lastpos, input int start_at,
                              input int cut_k, input int cut_mode, output bit cut);
        int acc;
        logic [7:0] d;
        bit lst;
        cut = 0;
        acc = 0;
        for (int k = 0; k < nv; k++) begin
            @(negedge clk);
            bus.fc_valid_i = 1'b0;
            bus.fc_last_i  = 1'b0;
            bus.start_i    = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (k == cut_k) begin
                cut = 1;
                if (cut_mode == 1) begin
                    bus.abort_i = 1'b1;
                    @(negedge clk);
                    bus.abort_i = 1'b0;
                    chk("busy_after_abort", int'(bus.busy_o), 0);
                    chk("wren_after_abort", int'(bus.ifmap_wren_o), 0);
                end else begin
                    #2 rst = 1'b1;
                    #1;
                    chk("rst_busy", int'(bus.busy_o), 0);
                    chk("rst_err", int'(bus.err_o), 0);
                    chk("rst_in_num", int'(bus.fc_in_node_num_o), 0);
                    chk("rst_wren", int'(bus.ifmap_wren_o), 0);
                    chk("rst_done", int'(bus.done_o), 0);
                    wq.delete();
                    rq.delete();
                    cq.delete();
                    exp_err = 0;
                    @(negedge clk);
                    rst = 1'b0;
                end
                break;
            end
            d   = (k == 0) ? 8'hFB : 8'($urandom);
            lst = (k == lastpos - 1);
            bus.fc_valid_i  = 1'b1;
            bus.fc_result_i = d;
            bus.fc_last_i   = lst;
            if (k == start_at) bus.start_i = 1'b1;
            if (lst) begin
                if (acc != OUT_N[L] - 1) exp_err = 1;
                push_out(L, acc, d);
                break;
            end else if (acc == OUT_N[L] - 1) begin
                exp_err = 1;
            end else begin
                push_out(L, acc, d);
                acc++;
            end
        end
        if (!cut) begin
            @(negedge clk);
            bus.fc_valid_i = 1'b0;
            bus.fc_last_i  = 1'b0;
            bus.start_i    = 1'b0;
        end
    endtask

    task automatic settle(input string tag);
        repeat (8) @(negedge clk);
        chk({tag, "_done"}, done_seen, exp_done);
        chk({tag, "_err"}, int'(bus.err_o), exp_err);
        chk({tag, "_busy"}, int'(bus.busy_o), 0);
        chk({tag, "_pending"}, wq.size() + rq.size() + cq.size(), 0);
    endtask

    task automatic run_chain(input string tag, input int nv0, input int nv1, input int nv2,
                             input int start_at, input int cut_layer, input int cut_k,
                             input int cut_mode);
        int nv[3];
        bit cut;
        nv[0] = nv0; nv[1] = nv1; nv[2] = nv2;
        cut = 0;
        @(negedge clk);
        bus.start_i = 1'b1;
        exp_err = 0;
        push_cmd(0);
        wait_cmd();
        for (int L = 0; L < 3; L++) begin
            if (L > 0) begin
                push_cmd(L);
                wait_cmd();
            end
            send_layer(L, nv[L], nv[L], (L == 0) ? start_at : -1,
                       (L == cut_layer) ? cut_k : -1, cut_mode, cut);
            if (cut) break;
        end
        if (!cut) exp_done++;
        settle(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: no completion within time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        bus.fc_valid_i = 1'b0;
        bus.fc_last_i = 1'b0;
        bus.fc_result_i = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(bus.busy_o), 0);
        chk("reset_fc_start", int'(bus.fc_start_o), 0);
        chk("reset_wren", int'(bus.ifmap_wren_o), 0);
        chk("reset_result_valid", int'(bus.result_valid_o), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", int'(bus.busy_o), 0);
        chk("idle_done", int'(bus.done_o), 0);
        chk("idle_err", int'(bus.err_o), 0);
        chk("idle_nth", int'(bus.fc_nth_fully_o), 0);
        chk("idle_in", int'(bus.fc_in_node_num_o), 0);
        chk("idle_out", int'(bus.fc_out_node_num_o), 0);
        chk("idle_wrptr", int'(bus.ifmap_wrptr_o), 0);

        // Nominal run, with an ignored start_i mid layer0.
        run_chain("nominal", 120, 84, 10, 5, -1, -1, 0);
        // Early last on the 50th output of layer1.
        run_chain("early_last", 120, 50, 10, -1, -1, -1, 0);
        // Layer2 overrun: two extra samples before last.
        run_chain("overrun", 120, 84, 12, -1, -1, -1, 0);
        // Layer0 overrun sets err, then abort at idx 30 of layer1.
        run_chain("abort", 121, 84, 10, -1, 1, 30, 1);
        // Restart clears err and begins at nth 0.
        run_chain("restart", 120, 84, 10, -1, -1, -1, 0);
        // Asynchronous reset mid layer0.
        run_chain("async_rst", 120, 84, 10, -1, 0, 20, 2);

        // fc_valid_i while idle: flagged, nothing written.
        @(negedge clk);
        bus.fc_valid_i = 1'b1;
        bus.fc_result_i = 8'h33;
        @(negedge clk);
        bus.fc_valid_i = 1'b0;
        exp_err = 1;
        @(negedge clk);
        chk("idle_valid_err", int'(bus.err_o), 1);
        settle("idle_valid");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
